// File: rtl/alu_share_pkg.sv
// Shared definitions for the two-client ALU arbiter: FSM states, ALU control
// codes and the legal-code check used to suppress undefined operations.
package alu_share_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLL  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_SLT  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1101;
    localparam logic [3:0] ALU_PASS = 4'b1111;

    function automatic logic alu_ctr_legal(input logic [3:0] ctr);
        logic legal;
        case (ctr)
            ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL,
            ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU, ALU_PASS: legal = 1'b1;
            default:                                       legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/alu_share_arbiter_pick.sv
// Two-way round-robin pick: a lone requester wins; on a tie the requester that
// was not granted last time wins. Output is one-hot, or zero when nobody asks.
module alu_rr_pick2 (
    input  logic [1:0] req_valid,
    input  logic       last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        case (req_valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Arbiter/sequencer sharing one ALU between two clients: round-robin accept,
// one registered EXEC cycle, then a held response until the owner takes it.
module alu_share_arbiter
    import alu_share_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [1:0]           req_valid,
    output logic [1:0]           req_ready,
    input  logic [1:0][3:0]      req_ctr,
    input  logic [1:0][XLEN-1:0] req_a,
    input  logic [1:0][XLEN-1:0] req_b,
    output logic [1:0]           rsp_valid,
    input  logic [1:0]           rsp_ready,
    output logic [XLEN-1:0]      rsp_data,
    output logic                 rsp_zero,
    output logic                 rsp_err,
    output logic [3:0]           alu_ctr,
    output logic [XLEN-1:0]      alu_a,
    output logic [XLEN-1:0]      alu_b,
    input  logic [XLEN-1:0]      alu_result,
    input  logic                 alu_zero
);

    state_t            state_reg, state_next;
    logic              last_grant_reg;
    logic              owner_reg;
    logic [3:0]        ctr_reg;
    logic [XLEN-1:0]   a_reg, b_reg;
    logic [XLEN-1:0]   rsp_data_reg;
    logic              rsp_zero_reg;
    logic              rsp_err_reg;

    logic [1:0]        grant;
    logic              win;
    logic              accept;
    logic              legal;
    logic              handshake;

    alu_rr_pick2 u_pick (
        .req_valid  (req_valid),
        .last_grant (last_grant_reg),
        .grant      (grant)
    );

    assign win       = grant[1];
    assign accept    = (state_reg == IDLE) && (grant != 2'b00);
    assign legal     = alu_ctr_legal(ctr_reg);
    assign handshake = (state_reg == HOLD) && rsp_ready[owner_reg];

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = EXEC;
            EXEC:    state_next = HOLD;
            HOLD:    if (handshake) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            last_grant_reg <= 1'b1;
            owner_reg      <= 1'b0;
            ctr_reg        <= 4'b0000;
            a_reg          <= '0;
            b_reg          <= '0;
            rsp_data_reg   <= '0;
            rsp_zero_reg   <= 1'b0;
            rsp_err_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                ctr_reg        <= req_ctr[win];
                a_reg          <= req_a[win];
                b_reg          <= req_b[win];
                owner_reg      <= win;
                last_grant_reg <= win;
            end
            // Illegal codes never reach the ALU, so their result is forced clean.
            if (state_reg == EXEC) begin
                rsp_data_reg <= legal ? alu_result : '0;
                rsp_zero_reg <= legal ? alu_zero : 1'b0;
                rsp_err_reg  <= ~legal;
            end
        end
    end

    always_comb begin
        req_ready = (state_reg == IDLE) ? grant : 2'b00;
        rsp_valid = 2'b00;
        if (state_reg == HOLD) rsp_valid = owner_reg ? 2'b10 : 2'b01;
        alu_ctr = 4'b0000;
        alu_a   = '0;
        alu_b   = '0;
        if ((state_reg == EXEC) && legal) begin
            alu_ctr = ctr_reg;
            alu_a   = a_reg;
            alu_b   = b_reg;
        end
    end

    assign rsp_data = rsp_data_reg;
    assign rsp_zero = rsp_zero_reg;
    assign rsp_err  = rsp_err_reg;

endmodule
